// File: rtl/config_pkg.sv
// Shared types and constants for the config chain and its serial loader.
package config_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } loaderStateT;

    localparam int ClockConfigWidth  = 4;
    localparam int SymCoeffsWidth    = 1;
    localparam int ConfigChainLength = ClockConfigWidth + SymCoeffsWidth;

    localparam logic [ConfigChainLength-1:0] DefaultConfig = 5'b11111;

endpackage

// File: rtl/shift_tick.sv
// Prescaler: while enabled, emits a one-cycle tick every ShiftDiv+1 cycles.
module shift_tick #(
    parameter int ShiftDiv = 0,
    parameter int DivWidth = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [DivWidth-1:0] DivLast = DivWidth'(ShiftDiv);

    logic [DivWidth-1:0] divCnt;

    // Tick is decoded from the counter register, so it is glitch-free and aligned to the cycle.
    assign tick = enable && (divCnt == DivLast);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            divCnt <= '0;
        end else if (clear) begin
            divCnt <= '0;
        end else if (enable) begin
            if (divCnt == DivLast) begin
                divCnt <= '0;
            end else begin
                divCnt <= divCnt + DivWidth'(1);
            end
        end
    end

endmodule

// File: rtl/config_loader.sv
// Serial programming master: shifts a config word MSB-first into the chain
// while capturing the chain's previous contents as a readback word.
module config_loader
    import config_pkg::*;
#(
    parameter int ChainLength = ConfigChainLength,
    parameter int ShiftDiv    = 0,
    parameter int DivWidth    = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   start,
    input  logic [ChainLength-1:0] txData,
    output logic                   ready,
    output logic                   done,
    output logic [ChainLength-1:0] rxData,
    output logic                   serialEn,
    output logic                   serialOut,
    input  logic                   serialIn
);

    localparam int CntWidth = $clog2(ChainLength + 1);
    localparam logic [CntWidth-1:0] LastBit = CntWidth'(ChainLength - 1);

    loaderStateT state;
    loaderStateT stateNext;

    logic [ChainLength-1:0] txReg;
    logic [ChainLength-1:0] rxReg;
    logic [CntWidth-1:0]    bitCnt;
    logic                   tick;
    logic                   accept;
    logic                   lastPulse;

    assign accept    = (state == IDLE) && start;
    assign lastPulse = tick && (bitCnt == LastBit);

    shift_tick #(
        .ShiftDiv (ShiftDiv),
        .DivWidth (DivWidth)
    ) prescaler (
        .clk    (clk),
        .resetN (resetN),
        .enable (state == SHIFT),
        .clear  (accept),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        ready     = 1'b0;
        done      = 1'b0;
        serialOut = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                serialOut = txReg[ChainLength-1];
                if (lastPulse) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // serialIn is sampled on the enable edge itself, i.e. before the chain moves.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            txReg  <= '0;
            rxReg  <= '0;
            bitCnt <= '0;
        end else if (accept) begin
            txReg  <= txData;
            rxReg  <= '0;
            bitCnt <= '0;
        end else if (tick) begin
            txReg  <= {txReg[ChainLength-2:0], 1'b0};
            rxReg  <= {rxReg[ChainLength-2:0], serialIn};
            bitCnt <= bitCnt + CntWidth'(1);
        end
    end

    assign serialEn = tick;
    assign rxData   = rxReg;

endmodule

// File: doc/config_loader.md
# config_loader

Serial programming master for the config shift-register chain. Takes a parallel config word on a start strobe and shifts it MSB-first into the chain through `serialOut`/`serialEn`. While shifting, it captures the chain's returning `serialIn` stream, so the previous chain contents are available as a readback word when the transfer completes. It sits between the host/register interface and the config store at the far end of the serial link.

## Interface
Parameters:
- `ChainLength`, default 5: total chain length in bits (clock config width 4 + symmetric-coeffs flag 1).
- `ShiftDiv`, default 0: idle cycles between shift pulses. `serialEn` pulses once every `ShiftDiv+1` cycles.
- `DivWidth`, default 8: width of the prescaler counter. `ShiftDiv` must be at most 2^DivWidth-1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transfer; sampled only while `ready`=1.
- `txData`  in  ChainLength  word to load; bit ChainLength-1 is sent first.
- `ready`  out  1  idle and accepting `start`.
- `done`  out  1  one-cycle pulse at the end of a transfer.
- `rxData`  out  ChainLength  previous chain contents; valid from `done` until the next accepted `start`.
- `serialEn`  out  1  shift enable to the chain.
- `serialOut`  out  1  data to the chain's serial input.
- `serialIn`  in  1  data from the chain's serial output (chain MSB).

## Operation
- States:
  - IDLE: `ready`=1.
  - SHIFT: `ready`=0.
  - DONE: `ready`=0, `done`=1 for exactly one cycle.
- Transitions:
  - IDLE→SHIFT on `start`=1. The same edge loads `txReg`←`txData`, clears `rxReg`, and clears both the bit counter and the divider counter.
  - SHIFT→DONE on the edge that completes the ChainLength-th pulse.
  - DONE→IDLE unconditionally.
- `start` is ignored in SHIFT and DONE and is not queued. A `start` held high re-triggers on the first IDLE cycle.
- `serialOut` = `txReg[ChainLength-1]`, registered. It is 0 in IDLE.
- `serialEn` = (state==SHIFT) && (divCnt==ShiftDiv), decoded from registers only.
- Divider: in SHIFT it counts from 0 to ShiftDiv and wraps to 0 on a pulse.
- On every edge where `serialEn`=1:
  - `txReg` shifts left with 0 filled in.
  - `rxReg` ← {rxReg[ChainLength-2:0], `serialIn`}.
  - Bit counter increments.
- `serialIn` is sampled in the same cycle as `serialEn`, i.e. before the chain itself shifts. After ChainLength pulses the chain holds `txData` and `rxReg` holds the old chain word, MSB first.
- `rxData` = `rxReg`. It is held through IDLE and cleared on acceptance of the next `start`.
- Bit counter width is $clog2(ChainLength+1). Terminal count is ChainLength-1 at a pulse.

## Timing
- Reset values (asynchronous, take effect immediately): state IDLE, `ready`=1, `done`=0, `serialEn`=0, `serialOut`=0, `rxData`=0, all counters 0.
- `start` sampled at edge T gives:
  - SHIFT from cycle T+1.
  - Pulse k (k = 0..ChainLength-1) high in cycle T+1+k(ShiftDiv+1)+ShiftDiv.
  - `done` high in the cycle after the last pulse.
  - `ready` back one cycle after `done`.
- Start-to-`done` is ChainLength·(ShiftDiv+1)+1 cycles. With defaults: pulses in T+1..T+5, `done` at T+6, `ready` at T+7.
- Reset mid-transfer aborts immediately. No `done` is produced. The chain is left partially shifted, and software must reload it.
- `txData` is don't-care after the accepting edge.

## Structure
- Shared package `config_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - localparams ClockConfigWidth=4, SymCoeffsWidth=1, and ConfigChainLength = their sum;
  - the default config word 5'b11111.
- One sub-module is natural: `shift_tick`, the prescaler. Inputs are enable and clear; output is the one-cycle tick.
- The FSM, `txReg`, `rxReg` and the bit counter stay in `config_loader`.
- The bench instantiates the real config store on the far end of the link, with its reset driven from the same `resetN`.

## Test plan
- Defaults, chain at reset value 5'b11111, `txData`=5'b01010: `serialOut` reads 0,1,0,1,0 on the five pulse cycles T+1..T+5; `done` at T+6; `rxData`=5'b11111; chain then reads clockConfig=4'hA, symCoeffs=0.
- Back-to-back: second load 5'b10011 gives `rxData`=5'b01010, and the chain then reads clockConfig=4'h3, symCoeffs=1.
- `ShiftDiv`=3: pulses every 4 cycles at T+4, T+8, T+12, T+16, T+20; `done` at T+21; `serialEn` never high for two consecutive cycles.
- `start` pulsed at T+2 and again in the DONE cycle: both ignored, exactly 5 pulses and one `done`, `ready` low throughout.
- `resetN` asserted asynchronously mid-cycle after pulse 2: outputs take reset values before the next edge, no `done`; a fresh load of 5'b00001 then completes normally.
- `start` held high continuously: a new transfer is accepted at the first `ready` cycle, giving period ChainLength·(ShiftDiv+1)+2 cycles per transfer.
